f7_op_identifier: RTL
=====================

# f7_op_identifier

Sequential decoder for the 2-bit `chave` operation code of the f7 logic unit, which computes OR, NOR, XOR or XNOR under `chave`. The block observes a stream of (a, b, result) samples taken from an f7 instance. It narrows a candidate set of operations until exactly one remains, then reports the recovered `chave`. It sits on the observation/checker side of the f7 datapath and is the inverse of f7: f7 maps (a, b, chave) to result; this block maps (a, b, result) back to chave.

## Interface
- MAX_SAMPLES, 8, samples accepted per identification before the block gives up (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a new identification; clears candidates and count
- sample_valid  in  1  a, b, result carry a valid observation this cycle
- a  in  1  f7 operand a
- b  in  1  f7 operand b
- result  in  1  f7 output for (a, b)
- sample_ready  out  1  high only in COLLECT
- busy  out  1  high in COLLECT
- done  out  1  identification succeeded; holds until start or reset
- error  out  1  no operation is consistent with the samples (conflict)
- timeout  out  1  MAX_SAMPLES consumed and candidates still ambiguous
- chave  out  2  recovered code: 00 OR, 01 NOR, 10 XOR, 11 XNOR; valid when done
- candidates  out  4  live mask; bit0 OR, bit1 NOR, bit2 XOR, bit3 XNOR
- sample_count  out  $clog2(MAX_SAMPLES+1)  samples accepted since start

## Operation
- States: IDLE, COLLECT, DONE, FAIL. FAIL is qualified by error or timeout.
- Reset (rst_n=0 at a clk edge) sets state IDLE and candidates=4'b1111. All other outputs go to 0, including chave=2'b00 and sample_count=0. Reset overrides everything, including start mid-collection.
- start=1 in any state: go to COLLECT with candidates=4'b1111 and sample_count=0. Clear done, error, timeout and chave.
- start and sample_valid in the same cycle: start wins and the sample is discarded.
- In COLLECT, a sample is accepted when sample_valid=1 and start=0:
  - exp = {~(a^b), a^b, ~(a|b), a|b}
  - match = ~(exp ^ {4{result}})
  - next_mask = candidates & match
  - sample_count increments.
- Resolution, evaluated on next_mask and the new count in the same edge as the update:
  - next_mask one-hot: go to DONE, done=1, chave = index of the set bit.
  - next_mask == 0: go to FAIL, error=1.
  - Otherwise, if the new count == MAX_SAMPLES: go to FAIL, timeout=1.
  - Otherwise stay in COLLECT.
- Priority: one-hot > zero > timeout.
- In IDLE, DONE and FAIL, sample_valid is ignored; candidates and count hold.
- A (1,1) sample splits the candidates into {OR,XNOR} or {NOR,XOR}. A (0,0), (0,1) or (1,0) sample splits them into {OR,XOR} or {NOR,XNOR}. Resolution therefore needs at least one (1,1) sample and one other sample.
- sample_count saturates at MAX_SAMPLES. It never wraps.

## Timing
- All outputs are registered. The update is visible the cycle after the accepting edge.
- Latency from start to sample_ready=1 is 1 cycle.
- Minimum identification is 2 accepted samples. done rises 1 cycle after the second accepting edge.
- Throughput is one sample per cycle while sample_ready=1. Handshake: a sample is accepted on any edge where sample_valid and sample_ready are both 1.
- done, error and timeout are mutually exclusive and level-held.
- busy equals sample_ready.

## Test plan
- Reset, then start, then samples (1,1,r=0) and (0,1,r=1). Candidates go 1111 → 0110 → 0100. Required: done=1, chave=2'b10, sample_count=2.
- Start, then samples (0,0,1) and (1,1,1). Required: candidates 1010 → 1000, done=1, chave=2'b11. Follow with a third sample_valid: it is ignored and count stays 2.
- Conflict: start, then (1,1,1) giving 1001, then (0,0,0) giving 0001 → done with chave=00. Then start again, feed (1,1,1) followed by (1,0,0). Required: 1001 → 1000 → done with chave=11, no error. Separately, feed (0,0,1) then (0,0,0) (candidates 1010 → 0000). Required: error=1, done=0.
- Timeout with MAX_SAMPLES=3: start, then three (0,1,1) samples. Candidates stay 0101. Required: timeout=1, sample_count=3, busy=0.
- start asserted together with sample_valid in COLLECT after one sample. Required: candidates=1111, sample_count=0, and the sample is discarded.
- rst_n=0 for one cycle mid-COLLECT with candidates=0110. Required next cycle: IDLE, candidates=1111, all flags 0, sample_ready=0.

Source files
------------

// File: rtl/f7_op_identifier.sv
// f7_op_identifier: recovers the 2-bit chave code of an f7 logic unit
// (OR / NOR / XOR / XNOR) from observed (a, b, result) samples.
// Each accepted sample removes every operation that disagrees with it.
// The block stops when one candidate remains (done), when none remain
// (error), or when MAX_SAMPLES samples have not narrowed the set (timeout).
//
// Handshake: a sample is taken on any rising edge where sample_valid and
// sample_ready are both 1. sample_ready is high only while collecting.
// start has priority over sample_valid, so a sample presented in the same
// cycle as start is dropped.
module f7_op_identifier #(
    parameter int MAX_SAMPLES = 8,
    localparam int CW = $clog2(MAX_SAMPLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sample_valid,
    input  logic          a,
    input  logic          b,
    input  logic          result,
    output logic          sample_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          timeout,
    output logic [1:0]    chave,
    output logic [3:0]    candidates,
    output logic [CW-1:0] sample_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        FAIL    = 2'd3
    } state_t;

    state_t state;

    logic [3:0]    exp_bits;
    logic [3:0]    match;
    logic [3:0]    next_mask;
    logic          next_onehot;
    logic [1:0]    next_index;
    logic [CW-1:0] next_count;

    // Candidate narrowing and resolution inputs for the current sample
    always_comb begin
        // Bit order matches chave: 0 OR, 1 NOR, 2 XOR, 3 XNOR
        exp_bits    = {~(a ^ b), a ^ b, ~(a | b), a | b};
        match       = ~(exp_bits ^ {4{result}});
        next_mask   = candidates & match;
        next_onehot = (next_mask != 4'b0000) &&
                      ((next_mask & (next_mask - 4'd1)) == 4'b0000);
        next_index  = 2'd0;
        case (next_mask)
            4'b0001: next_index = 2'd0;
            4'b0010: next_index = 2'd1;
            4'b0100: next_index = 2'd2;
            4'b1000: next_index = 2'd3;
            default: next_index = 2'd0;
        endcase
        // Saturate so the counter can never wrap
        if (sample_count == CW'(MAX_SAMPLES))
            next_count = sample_count;
        else
            next_count = sample_count + CW'(1);
    end

    // Identification FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            candidates   <= 4'b1111;
            sample_count <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            timeout      <= 1'b0;
            chave        <= 2'b00;
        end else if (start) begin
            state        <= COLLECT;
            candidates   <= 4'b1111;
            sample_count <= '0;
            sample_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            timeout      <= 1'b0;
            chave        <= 2'b00;
        end else begin
            case (state)
                COLLECT: begin
                    if (sample_valid) begin
                        candidates   <= next_mask;
                        sample_count <= next_count;
                        if (next_onehot) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            chave        <= next_index;
                            sample_ready <= 1'b0;
                            busy         <= 1'b0;
                        end else if (next_mask == 4'b0000) begin
                            state        <= FAIL;
                            error        <= 1'b1;
                            sample_ready <= 1'b0;
                            busy         <= 1'b0;
                        end else if (next_count == CW'(MAX_SAMPLES)) begin
                            state        <= FAIL;
                            timeout      <= 1'b1;
                            sample_ready <= 1'b0;
                            busy         <= 1'b0;
                        end
                    end
                end
                // IDLE, DONE and FAIL hold everything until start or reset
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
